jtframe_dwnld_banks: RTL and testbench
======================================

# jtframe_dwnld_banks

Converts the byte-serial ioctl ROM download stream into 16-bit SDRAM write requests spread over up to four SDRAM banks, with an optional PROM region. It sits between the framework ioctl interface and `jtframe_sdram`, replacing the single-bank downloader. It adds per-bank base offsets, selectable byte-lane order, and a small request FIFO, so ioctl bytes are never lost while the SDRAM is slow to acknowledge.

## Interface
Parameters:
- `AW`, 22: SDRAM word-address width.
- `BA1_START`, `BA2_START`, `BA3_START`, `~25'd0`: byte offsets in the stream where banks 1..3 begin. `~0` disables the bank. Enabled starts are strictly increasing.
- `PROM_START`, `~25'd0`: stream offset where PROM bytes begin. `~0` disables the PROM region.
- `SWAB`, 0: 0 puts odd bytes in the low lane; 1 puts odd bytes in the high lane.
- `FIFO_DEPTH`, 4: request FIFO depth. Must be a power of two, at least 2.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `downloading`  in  1: download in progress.
- `ioctl_addr`  in  25: stream byte address.
- `ioctl_data`  in  8: stream byte.
- `ioctl_wr`  in  1: byte strobe, one cycle.
- `prog_addr`  out  AW: word address within the bank. For PROM requests it is the byte offset from `PROM_START`.
- `prog_data`  out  16: byte duplicated on both lanes.
- `prog_mask`  out  2: active-low lane enable.
- `prog_ba`  out  2: SDRAM bank.
- `prog_we`  out  1: SDRAM write request, held until acknowledged.
- `prom_we`  out  1: PROM write strobe, one cycle.
- `sdram_ack`  in  1: SDRAM accepted the request.
- `fifo_ovf`  out  1: sticky flag, a byte was dropped.
- `dwnld_done`  out  1: one-cycle pulse when the download has fully drained.

## Operation
- Decode on `ioctl_wr && downloading`:
  - PROM if the PROM region is enabled and `addr >= PROM_START`.
  - Otherwise the highest enabled bank n with `addr >= BAn_START`, else bank 0.
  - `off = addr - start`. SDRAM word address is `off[AW:1]`.
  - Mask is `2'b10` when `off[0]^SWAB` = 1, otherwise `2'b01`.
- The decoded entry `{is_prom, ba, addr, data, mask}` is pushed into the FIFO.
- Issue FSM:
  - IDLE: if the FIFO is not empty, pop the head and load the outputs. A PROM entry goes to PROM; an SDRAM entry goes to WAIT.
  - WAIT: `prog_we` = 1. On `sdram_ack`, clear `prog_we` and return to IDLE.
  - PROM: `prom_we` = 1 for exactly one cycle, then IDLE. No ack is involved.
- Outputs keep their last values while IDLE; only the strobes drop.
- Full FIFO:
  - A push with no simultaneous pop is dropped and sets `fifo_ovf`.
  - A push and a pop in the same cycle while full is accepted.
- `fifo_ovf` clears on the rising edge of `downloading`.
- `downloading` falling:
  - New pushes stop.
  - Queued entries still drain.
  - `dwnld_done` pulses on the first cycle with `downloading` = 0, the FIFO empty and the FSM in IDLE. It pulses once per download.
- `sdram_ack` while not in WAIT is ignored.
- `ioctl_wr` while `downloading` = 0 is ignored.

## Timing
- Reset (asynchronous assert): FIFO emptied, FSM to IDLE, all outputs 0. `prog_mask` resets to `2'b11`.
- Latency: `ioctl_wr` in cycle t gives the FIFO write at t+1. With the FIFO empty, `prog_we`/`prom_we` are high from t+2.
- `prog_we` falls in the cycle after `sdram_ack` is sampled high. The next request can rise no earlier than the cycle after that, so there is a 1-cycle gap.
- A PROM entry occupies 2 FSM cycles (strobe, then IDLE).
- Address arithmetic is 25-bit unsigned. Offset bits above AW are truncated silently.

## Structure
- Shared package `jtframe_dwnld_pkg`: FIFO entry field layout/widths, FSM state encoding (IDLE, WAIT, PROM), and the disabled-region constant `~25'd0`.
- Sub-module `jtframe_dwnld_fifo`: synchronous FIFO, parameter DEPTH/WIDTH, with full/empty flags and same-cycle push/pop.
- The top level holds the region decoder, the issue FSM and the done/overflow logic.

## Test plan
- Bank split: `BA1_START` = 0x100000. Byte 0xA5 at addr 0x100003, ack after 1 cycle. Expect `prog_ba` = 1, `prog_addr` = 0x1, `prog_mask` = 2'b10, `prog_data` = 0xA5A5, and `prog_we` high at t+2.
- SWAB: same byte with `SWAB` = 1. Expect `prog_mask` = 2'b01.
- PROM: `PROM_START` = 0x200000, byte at 0x200005. Expect a one-cycle `prom_we`, `prog_addr` = 5, `prog_we` = 0, and no ack needed.
- Backpressure: `FIFO_DEPTH` = 4, 6 back-to-back bytes, ack held low for 20 cycles. Expect the first 5 written in order (1 in flight + 4 queued), the 6th dropped and `fifo_ovf` = 1. After a new `downloading` rise, expect `fifo_ovf` = 0.
- Drain/done: drop `downloading` with 3 entries queued. Expect all 3 issued, then a single `dwnld_done` pulse after the last ack.
- Reset mid-transfer: assert `rst_n` = 0 while in WAIT with a non-empty FIFO. Expect all outputs 0 (mask `2'b11`) immediately, and no requests after release.

Source files
------------

// File: rtl/jtframe_dwnld_pkg.sv
// jtframe_dwnld_pkg: shared FIFO entry layout, issue FSM states and the disabled-region marker
package jtframe_dwnld_pkg;
  localparam logic [24:0] REGION_OFF = '1;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_PROM} state_t;
  typedef struct packed {
    logic        is_prom;
    logic [1:0]  ba;
    logic [24:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
  } entry_t;
  localparam int ENTRY_W = $bits(entry_t);
endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// jtframe_dwnld_fifo: synchronous FIFO (push/din in, pop/dout out, full/empty flags), push accepted when full if popping in the same cycle
module jtframe_dwnld_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] cnt;
  logic wr_en, rd_en;
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign full  = cnt == (PW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout  = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (PW+1)'(wr_en) - (PW+1)'(rd_en);
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= din;
endmodule

// File: rtl/jtframe_dwnld_banks.sv
// jtframe_dwnld_banks: ioctl byte stream to 16-bit multi-bank SDRAM write requests plus PROM strobes
// ports: ioctl_* stream in; prog_* SDRAM request out (prog_we held until sdram_ack); prom_we one-cycle PROM strobe; fifo_ovf sticky drop flag; dwnld_done drain pulse
module jtframe_dwnld_banks import jtframe_dwnld_pkg::*; #(
  parameter int          AW         = 22,
  parameter logic [24:0] BA1_START  = REGION_OFF,
  parameter logic [24:0] BA2_START  = REGION_OFF,
  parameter logic [24:0] BA3_START  = REGION_OFF,
  parameter logic [24:0] PROM_START = REGION_OFF,
  parameter bit          SWAB       = 1'b0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          downloading,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_data,
  input  logic          ioctl_wr,
  output logic [AW-1:0] prog_addr,
  output logic [15:0]   prog_data,
  output logic [1:0]    prog_mask,
  output logic [1:0]    prog_ba,
  output logic          prog_we,
  output logic          prom_we,
  input  logic          sdram_ack,
  output logic          fifo_ovf,
  output logic          dwnld_done
);
  logic push, pop, full, empty, dl_q, armed, is_prom;
  logic [1:0] ba;
  logic [24:0] start, off;
  entry_t din, head;
  state_t state, next;
  logic unused_bits;
  assign is_prom = PROM_START != REGION_OFF && ioctl_addr >= PROM_START;
  assign ba = BA3_START != REGION_OFF && ioctl_addr >= BA3_START ? 2'd3 :
              BA2_START != REGION_OFF && ioctl_addr >= BA2_START ? 2'd2 :
              BA1_START != REGION_OFF && ioctl_addr >= BA1_START ? 2'd1 : 2'd0;
  assign start = is_prom ? PROM_START : ba == 2'd3 ? BA3_START : ba == 2'd2 ? BA2_START :
                 ba == 2'd1 ? BA1_START : '0;
  assign off  = ioctl_addr - start;
  assign push = ioctl_wr && downloading;
  // PROM entries keep the byte offset, SDRAM entries the word offset
  assign din = '{is_prom, ba, is_prom ? off : {1'b0, off[24:1]}, ioctl_data,
                 (off[0] ^ SWAB) ? 2'b10 : 2'b01};
  assign unused_bits = ^head.addr[24:AW];
  jtframe_dwnld_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din),
    .dout(head), .full(full), .empty(empty)
  );
  always_comb begin
    pop  = state == ST_IDLE && !empty;
    next = pop ? (head.is_prom ? ST_PROM : ST_WAIT) :
           state == ST_PROM ? ST_IDLE :
           state == ST_WAIT && sdram_ack ? ST_IDLE : state;
  end
  assign prog_we    = state == ST_WAIT;
  assign prom_we    = state == ST_PROM;
  assign dwnld_done = armed && !downloading && empty && state == ST_IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= ST_IDLE;
      dl_q      <= 1'b0;
      armed     <= 1'b0;
      fifo_ovf  <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= 2'b11;
      prog_ba   <= '0;
    end else begin
      state    <= next;
      dl_q     <= downloading;
      armed    <= downloading || (armed && !dwnld_done);
      fifo_ovf <= (fifo_ovf && !(downloading && !dl_q)) || (push && full && !pop);
      if (pop) begin
        prog_addr <= head.addr[AW-1:0];
        prog_data <= {2{head.data}};
        prog_mask <= head.mask;
        prog_ba   <= head.ba;
      end
    end
endmodule

// File: tb/tb_jtframe_dwnld_banks.sv
// tb_jtframe_dwnld_banks: directed scoreboard bench for the banked ioctl downloader
module tb_jtframe_dwnld_banks;
  typedef struct packed {
    logic        prom;
    logic [1:0]  ba;
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  mask;
    logic [1:0]  mask_sw;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b1, downloading = 1'b0, ioctl_wr = 1'b0, sdram_ack = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0] ioctl_data = '0;
  logic [21:0] prog_addr, sw_addr;
  logic [15:0] prog_data, sw_data;
  logic [1:0] prog_mask, prog_ba, sw_mask, sw_ba;
  logic prog_we, prom_we, fifo_ovf, dwnld_done, sw_we, sw_prom_we, sw_ovf, sw_done;
  int tests = 0, fails = 0, done_cnt = 0;
  exp_t q[$];
  jtframe_dwnld_banks #(.AW(22), .BA1_START(25'h100000), .BA2_START(25'h180000),
    .PROM_START(25'h200000), .SWAB(1'b0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading), .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_mask(prog_mask), .prog_ba(prog_ba), .prog_we(prog_we), .prom_we(prom_we),
    .sdram_ack(sdram_ack), .fifo_ovf(fifo_ovf), .dwnld_done(dwnld_done));
  jtframe_dwnld_banks #(.AW(22), .BA1_START(25'h100000), .BA2_START(25'h180000),
    .PROM_START(25'h200000), .SWAB(1'b1), .FIFO_DEPTH(4)) u_swab (
    .clk(clk), .rst_n(rst_n), .downloading(downloading), .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .prog_addr(sw_addr), .prog_data(sw_data),
    .prog_mask(sw_mask), .prog_ba(sw_ba), .prog_we(sw_we), .prom_we(sw_prom_we),
    .sdram_ack(sdram_ack), .fifo_ovf(sw_ovf), .dwnld_done(sw_done));
  always #5 clk = ~clk;
  always @(negedge clk) if (dwnld_done) done_cnt++;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask
  function automatic exp_t model(input logic [24:0] a, input logic [7:0] d);
    exp_t e;
    logic [24:0] st, off;
    e.prom = a >= 25'h200000;
    e.ba = a >= 25'h180000 ? 2'd2 : a >= 25'h100000 ? 2'd1 : 2'd0;
    st = e.prom ? 25'h200000 : e.ba == 2'd2 ? 25'h180000 : e.ba == 2'd1 ? 25'h100000 : 25'h0;
    off = a - st;
    e.addr = e.prom ? off[21:0] : off[22:1];
    e.data = {d, d};
    e.mask = off[0] ? 2'b10 : 2'b01;
    e.mask_sw = off[0] ? 2'b01 : 2'b10;
    return e;
  endfunction
  task automatic write(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr = 1'b1;
    step();
    ioctl_wr = 1'b0;
  endtask
  task automatic serve(input int dly);
    exp_t e;
    int n;
    n = 0;
    while (!(prog_we || prom_we) && n < 50) begin step(); n++; end
    check("req_strobe", {31'd0, prog_we | prom_we}, 32'd1);
    if (!(prog_we || prom_we)) return;
    check("sb_nonempty", {31'd0, q.size() != 0}, 32'd1);
    if (q.size() == 0) return;
    e = q.pop_front();
    check("prom_we", {31'd0, prom_we}, {31'd0, e.prom});
    check("prog_we", {31'd0, prog_we}, {31'd0, !e.prom});
    check("addr", {10'd0, prog_addr}, {10'd0, e.addr});
    check("data", {16'd0, prog_data}, {16'd0, e.data});
    if (e.prom) begin
      step();
      check("prom_we_one_cycle", {31'd0, prom_we}, 32'd0);
    end else begin
      check("ba", {30'd0, prog_ba}, {30'd0, e.ba});
      check("mask", {30'd0, prog_mask}, {30'd0, e.mask});
      check("swab_mask", {30'd0, sw_mask}, {30'd0, e.mask_sw});
      repeat (dly) step();
      check("we_held", {31'd0, prog_we}, 32'd1);
      sdram_ack = 1'b1;
      step();
      sdram_ack = 1'b0;
      check("we_drop", {31'd0, prog_we}, 32'd0);
      check("done", {31'd0, dwnld_done}, {31'd0, !downloading && q.size() == 0});
    end
  endtask
  initial begin
    logic [24:0] tbl [8];
    logic seen;
    int d0;
    tbl = '{25'h000000, 25'h000001, 25'h0FFFFF, 25'h100000, 25'h17FFFF,
            25'h180000, 25'h1FFFFF, 25'h200000};
    #1 rst_n = 1'b0;
    step();
    step();
    check("rst_we", {31'd0, prog_we}, 32'd0);
    check("rst_prom_we", {31'd0, prom_we}, 32'd0);
    check("rst_mask", {30'd0, prog_mask}, 32'd3);
    check("rst_addr", {10'd0, prog_addr}, 32'd0);
    check("rst_data", {16'd0, prog_data}, 32'd0);
    check("rst_ba", {30'd0, prog_ba}, 32'd0);
    check("rst_ovf", {31'd0, fifo_ovf}, 32'd0);
    check("rst_done", {31'd0, dwnld_done}, 32'd0);
    rst_n = 1'b1;
    downloading = 1'b1;
    step();
    write(25'h100003, 8'hA5);
    check("we_t1", {31'd0, prog_we}, 32'd0);
    step();
    check("we_t2", {31'd0, prog_we}, 32'd1);
    check("split_ba", {30'd0, prog_ba}, 32'd1);
    check("split_addr", {10'd0, prog_addr}, 32'd1);
    check("split_mask", {30'd0, prog_mask}, 32'd2);
    check("split_data", {16'd0, prog_data}, 32'hA5A5);
    check("swab_split_mask", {30'd0, sw_mask}, 32'd1);
    q.push_back(model(25'h100003, 8'hA5));
    serve(1);
    step();
    write(25'h200005, 8'h3C);
    step();
    check("prom_strobe", {31'd0, prom_we}, 32'd1);
    check("prom_addr", {10'd0, prog_addr}, 32'd5);
    check("prom_no_we", {31'd0, prog_we}, 32'd0);
    q.push_back(model(25'h200005, 8'h3C));
    serve(0);
    foreach (tbl[i]) begin
      logic [7:0] d;
      d = 8'($urandom);
      write(tbl[i], d);
      q.push_back(model(tbl[i], d));
      serve(i % 3);
    end
    for (int i = 0; i < 6; i++) begin
      write(25'h000010 + 25'(i), 8'h10 + 8'(i));
      if (i < 5) q.push_back(model(25'h000010 + 25'(i), 8'h10 + 8'(i)));
    end
    check("ovf_set", {31'd0, fifo_ovf}, 32'd1);
    serve(20);
    for (int i = 0; i < 4; i++) serve(i);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin step(); seen |= prog_we | prom_we; end
    check("sixth_dropped", {31'd0, seen}, 32'd0);
    check("ovf_sticky", {31'd0, fifo_ovf}, 32'd1);
    downloading = 1'b0;
    step();
    downloading = 1'b1;
    step();
    check("ovf_clear", {31'd0, fifo_ovf}, 32'd0);
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      write(25'h180020 + 25'(i), 8'hC0 + 8'(i));
      q.push_back(model(25'h180020 + 25'(i), 8'hC0 + 8'(i)));
    end
    downloading = 1'b0;
    step();
    check("no_early_done", 32'(done_cnt - d0), 32'd0);
    for (int i = 0; i < 4; i++) serve(2);
    repeat (5) step();
    check("done_once", 32'(done_cnt - d0), 32'd1);
    d0 = done_cnt;
    write(25'h000040, 8'h55);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin step(); seen |= prog_we | prom_we; end
    check("wr_ignored", {31'd0, seen}, 32'd0);
    check("no_extra_done", 32'(done_cnt - d0), 32'd0);
    downloading = 1'b1;
    step();
    for (int i = 0; i < 3; i++) write(25'h100100 + 25'(i), 8'h70 + 8'(i));
    check("pre_rst_we", {31'd0, prog_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_we", {31'd0, prog_we}, 32'd0);
    check("arst_mask", {30'd0, prog_mask}, 32'd3);
    check("arst_addr", {10'd0, prog_addr}, 32'd0);
    check("arst_data", {16'd0, prog_data}, 32'd0);
    check("arst_ba", {30'd0, prog_ba}, 32'd0);
    step();
    rst_n = 1'b1;
    sdram_ack = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin step(); seen |= prog_we | prom_we; end
    sdram_ack = 1'b0;
    check("no_req_after_rst", {31'd0, seen}, 32'd0);
    downloading = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
